plab4_net_tdm_link_arb: RTL

//  Time-division arbiter for one outgoing ring link of a domain-separated router.

---
 rtl/plab4_net_tdm_link_arb_pkg.sv | 16 +
 rtl/plab4_net_rr_arb3.sv | 20 ++
 rtl/plab4_net_tdm_link_arb.sv | 95 +++++++++
 3 files changed

// File: rtl/plab4_net_tdm_link_arb_pkg.sv
// plab4_net_tdm_link_arb_pkg: domain and port encodings shared by the TDM link arbiter
package plab4_net_tdm_link_arb_pkg;

    localparam logic DOM_0 = 1'b0;
    localparam logic DOM_1 = 1'b1;

    localparam logic [1:0] PORT_FWD   = 2'd0;
    localparam logic [1:0] PORT_TERM  = 2'd1;
    localparam logic [1:0] PORT_BACKW = 2'd2;

    // Round-robin successor of a one-hot grant: the port after the winner goes first next time
    function automatic logic [1:0] next_ptr(input logic [2:0] grant);
        return grant[PORT_FWD] ? PORT_TERM : grant[PORT_TERM] ? PORT_BACKW : PORT_FWD;
    endfunction

endpackage

// File: rtl/plab4_net_rr_arb3.sv
// plab4_net_rr_arb3: combinational 3-way round-robin arbiter with one-hot grant
module plab4_net_rr_arb3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] grant
);

    logic [5:0] dbl;
    logic [2:0] rot;
    logic [2:0] pick;
    logic [5:0] back;

    // Rotate requests so the pointer position is bit 0, pick the lowest, rotate back
    assign dbl   = {req, req};
    assign rot   = dbl[ptr +: 3];
    assign pick  = rot[0] ? 3'b001 : rot[1] ? 3'b010 : rot[2] ? 3'b100 : 3'b000;
    assign back  = {pick, pick} << ptr;
    assign grant = back[5:3];

endmodule

// File: rtl/plab4_net_tdm_link_arb.sv
// plab4_net_tdm_link_arb: time-division arbiter sharing one ring link between two security domains
module plab4_net_tdm_link_arb
    import plab4_net_tdm_link_arb_pkg::*;
#(
    parameter int p_msg_cnbits   = 32,
    parameter int p_msg_dnbits   = 32,
    parameter int p_slot_cycles  = 8,
    parameter int p_guard_cycles = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in0_val,
    output logic                    in0_rdy,
    input  logic                    in0_domain,
    input  logic [p_msg_cnbits-1:0] in0_msg_control,
    input  logic [p_msg_dnbits-1:0] in0_msg_data,
    input  logic                    in1_val,
    output logic                    in1_rdy,
    input  logic                    in1_domain,
    input  logic [p_msg_cnbits-1:0] in1_msg_control,
    input  logic [p_msg_dnbits-1:0] in1_msg_data,
    input  logic                    in2_val,
    output logic                    in2_rdy,
    input  logic                    in2_domain,
    input  logic [p_msg_cnbits-1:0] in2_msg_control,
    input  logic [p_msg_dnbits-1:0] in2_msg_data,
    output logic                    out_val,
    input  logic                    out_rdy,
    output logic [p_msg_cnbits-1:0] out_msg_control,
    output logic [p_msg_dnbits-1:0] out_msg_data,
    output logic                    out_domain
);

    localparam int            sw          = $clog2(p_slot_cycles);
    localparam logic [sw-1:0] slot_last   = sw'(p_slot_cycles - 1);
    localparam logic [sw-1:0] guard_start = sw'(p_slot_cycles - p_guard_cycles);

    logic [sw-1:0] slot_cnt;
    logic          cur_dom;
    logic [1:0]    rr_ptr0;
    logic [1:0]    rr_ptr1;
    logic [1:0]    ptr;
    logic          guard;
    logic          xfer;
    logic [2:0]    req;
    logic [2:0]    grant;

    // Reset gates the requests so every output drops to zero while reset is held
    assign guard = (p_guard_cycles != 0) && (slot_cnt >= guard_start);
    assign req   = {in2_val & (in2_domain == cur_dom),
                    in1_val & (in1_domain == cur_dom),
                    in0_val & (in0_domain == cur_dom)} & {3{~guard & ~reset}};
    assign ptr   = (cur_dom == DOM_1) ? rr_ptr1 : rr_ptr0;

    plab4_net_rr_arb3 u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (grant)
    );

    assign out_val                     = |grant;
    assign xfer                        = out_val & out_rdy;
    assign {in2_rdy, in1_rdy, in0_rdy} = grant & {3{out_rdy}};
    assign out_domain                  = cur_dom;
    assign out_msg_control = grant[0] ? in0_msg_control : grant[1] ? in1_msg_control :
                             grant[2] ? in2_msg_control : '0;
    assign out_msg_data    = grant[0] ? in0_msg_data : grant[1] ? in1_msg_data :
                             grant[2] ? in2_msg_data : '0;

    // Free-running slot counter; the owning domain flips as the counter wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt <= '0;
            cur_dom  <= DOM_0;
        end else if (slot_cnt == slot_last) begin
            slot_cnt <= '0;
            cur_dom  <= ~cur_dom;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Per-domain round-robin pointers advance only on a completed transfer in their own domain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr0 <= PORT_FWD;
            rr_ptr1 <= PORT_FWD;
        end else if (xfer && cur_dom == DOM_1) begin
            rr_ptr1 <= next_ptr(grant);
        end else if (xfer) begin
            rr_ptr0 <= next_ptr(grant);
        end
    end

endmodule
